// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite single-port SRAM slave with sub-word writes, programmable read wait
// states, read-after-write forwarding and two-cycle ERROR responses.
module ahb3lite_sram_ws #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int RD_WAIT = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int         BYTES     = DATA_W / 8;
  localparam int         LANE_W    = (DATA_W == 64) ? 3 : 2;
  localparam int         WORD_AW   = ADDR_W - LANE_W;
  localparam int         DEPTH     = 1 << WORD_AW;
  localparam logic [2:0] MAX_SIZE  = 3'(LANE_W);
  localparam logic [2:0] LO_MASK   = 3'(BYTES - 1);
  localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

  typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} state_t;

  state_t               state;
  logic [2:0]           wait_cnt;
  logic                 wr_pend;
  logic [WORD_AW-1:0]   wr_addr;
  logic [2:0]           wr_lo;
  logic [2:0]           wr_size;
  logic [DATA_W-1:0]    rd_buf;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 accept;
  logic                 legal;
  logic [2:0]           align_mask;
  logic [WORD_AW-1:0]   addr_word;
  logic [BYTES-1:0]     wr_be;
  logic [DATA_W-1:0]    fwd_word;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, HTRANS[0], HBURST, HPROT};
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign addr_word = HADDR[ADDR_W-1:LANE_W];

  always_comb begin
    align_mask = 3'b111;
    case (HSIZE)
      3'b000:  align_mask = 3'b000;
      3'b001:  align_mask = 3'b001;
      3'b010:  align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign legal = (HSIZE <= MAX_SIZE) && ((HADDR[2:0] & align_mask) == 3'b000);

  // Little-endian lane enables for the write currently in its data phase
  always_comb begin
    wr_be = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i >= int'(wr_lo) && i < int'(wr_lo) + (1 << wr_size)) wr_be[i] = 1'b1;
    end
  end

  // A read landing on the word being written sees the merged new data
  always_comb begin
    fwd_word = mem[addr_word];
    if (wr_pend && wr_addr == addr_word) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_pend && HREADYOUT) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      wait_cnt  <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_lo     <= '0;
      wr_size   <= '0;
      rd_buf    <= '0;
    end else begin
      wr_pend <= 1'b0;
      case (state)
        // ERR2 completes the error response and may accept a new transfer
        IDLE, ERR2: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          if (accept) begin
            if (!legal) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              if (!HWRITE) HRDATA <= '0;
            end else if (HWRITE) begin
              wr_pend <= 1'b1;
              wr_addr <= addr_word;
              wr_lo   <= HADDR[2:0] & LO_MASK;
              wr_size <= HSIZE;
            end else if (RD_WAIT == 0) begin
              HRDATA <= fwd_word;
            end else begin
              state     <= RWAIT;
              HREADYOUT <= 1'b0;
              wait_cnt  <= WAIT_INIT;
              rd_buf    <= fwd_word;
            end
          end
        end
        RWAIT: begin
          if (wait_cnt <= 3'd1) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRDATA    <= rd_buf;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Directed bench for ahb3lite_sram_ws: one instance with RD_WAIT=0 and one with
// RD_WAIT=3 share the bus signals and are selected individually through HSEL.
module tb_ahb3lite_sram_ws;

  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HALF  = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel3;
  logic [9:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata3, rdata;
  logic        ready0, ready3, ready;
  logic        resp0, resp3, resp;
  logic        use3;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rdata = use3 ? rdata3 : rdata0;
  assign ready = use3 ? ready3 : ready0;
  assign resp  = use3 ? resp3  : resp0;

  ahb3lite_sram_ws #(.DATA_W(32), .ADDR_W(10), .RD_WAIT(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HWDATA(hwdata), .HREADY(ready0), .HRDATA(rdata0), .HREADYOUT(ready0),
    .HRESP(resp0)
  );

  ahb3lite_sram_ws #(.DATA_W(32), .ADDR_W(10), .RD_WAIT(3)) dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HWDATA(hwdata), .HREADY(ready3), .HRDATA(rdata3), .HREADYOUT(ready3),
    .HRESP(resp3)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s3, input logic act, input logic wr,
                                input logic [2:0] sz, input logic [9:0] a);
    sel0   = act & ~s3;
    sel3   = act & s3;
    htrans = act ? 2'b10 : 2'b00;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    use3   = 1'b0;
    hwdata = '0;
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    #12;
    check_output("rst_ready", {31'd0, ready}, 32'd1);
    check_output("rst_resp", {31'd0, resp}, 32'd0);
    check_output("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Word write, idle gap, then read back with zero waits
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_WORD, 10'h004);
    step();
    hwdata = 32'hABCD1234;
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t1_wr_ready", {31'd0, ready}, 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
      check_output("t1_idle_ready", {31'd0, ready}, 32'd1);
      step();
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h004);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t1_rd_data", rdata, 32'hABCD1234);
    check_output("t1_rd_ready", {31'd0, ready}, 32'd1);
    check_output("t1_rd_resp", {31'd0, resp}, 32'd0);
    step();

    // Sub-word writes with junk on disabled lanes, read pipelined behind the halfword
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_BYTE, 10'h008);
    step();
    hwdata = 32'hEEEEEE11;
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_BYTE, 10'h009);
    step();
    hwdata = 32'hEEEE22EE;
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_HALF, 10'h00A);
    step();
    hwdata = 32'h4433EEEE;
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h008);
    check_output("t2_wr_ready", {31'd0, ready}, 32'd1);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t2_fwd_merge", rdata, 32'h44332211);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h008);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t2_committed", rdata, 32'h44332211);
    step();

    // Forwarding to the same word, and no forwarding to a different word
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_WORD, 10'h000);
    step();
    hwdata = 32'hCDEF9876;
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h000);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t3_fwd_same", rdata, 32'hCDEF9876);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_WORD, 10'h000);
    step();
    hwdata = 32'h5555AAAA;
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h004);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t3_fwd_other", rdata, 32'hABCD1234);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h000);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t3_commit", rdata, 32'h5555AAAA);
    step();

    // Misaligned word write, with a read accepted during ERR2
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_WORD, 10'h002);
    step();
    hwdata = 32'hDEADBEEF;
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t5_err1_ready", {31'd0, ready}, 32'd0);
    check_output("t5_err1_resp", {31'd0, resp}, 32'd1);
    step();
    check_output("t5_err2_ready", {31'd0, ready}, 32'd1);
    check_output("t5_err2_resp", {31'd0, resp}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h000);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t5_after_ready", {31'd0, ready}, 32'd1);
    check_output("t5_after_resp", {31'd0, resp}, 32'd0);
    check_output("t5_unmodified", rdata, 32'h5555AAAA);
    step();

    // Dword read and dword write on a 32-bit bus are both illegal
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_DWORD, 10'h008);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t5_dw_err1_ready", {31'd0, ready}, 32'd0);
    check_output("t5_dw_err1_resp", {31'd0, resp}, 32'd1);
    check_output("t5_dw_err1_rdata", rdata, 32'h0);
    step();
    check_output("t5_dw_err2_ready", {31'd0, ready}, 32'd1);
    check_output("t5_dw_err2_resp", {31'd0, resp}, 32'd1);
    check_output("t5_dw_err2_rdata", rdata, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b1, SZ_DWORD, 10'h008);
    step();
    hwdata = 32'h00000000;
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t5_dww_resp", {31'd0, resp}, 32'd1);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h008);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t5_dw_unmodified", rdata, 32'h44332211);
    step();

    // RD_WAIT=3 instance: wait states, zero-wait write, forwarding under waits
    use3 = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b1, SZ_WORD, 10'h004);
    step();
    hwdata = 32'h13572468;
    apply_stimulus(1'b1, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t4_wr_ready", {31'd0, ready}, 32'd1);
    step();
    apply_stimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 10'h004);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0, SZ_WORD, 10'h000);
    for (int i = 0; i < 3; i++) begin
      check_output("t4_wait", {31'd0, ready}, 32'd0);
      step();
    end
    check_output("t4_rd_ready", {31'd0, ready}, 32'd1);
    check_output("t4_rd_resp", {31'd0, resp}, 32'd0);
    check_output("t4_rd_data", rdata, 32'h13572468);
    apply_stimulus(1'b1, 1'b1, 1'b1, SZ_WORD, 10'h000);
    step();
    hwdata = 32'h0BADF00D;
    apply_stimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 10'h000);
    check_output("t4_wr_zero_wait", {31'd0, ready}, 32'd1);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0, SZ_WORD, 10'h000);
    for (int i = 0; i < 3; i++) begin
      check_output("t4_fwd_wait", {31'd0, ready}, 32'd0);
      step();
    end
    check_output("t4_fwd_ready", {31'd0, ready}, 32'd1);
    check_output("t4_fwd_data", rdata, 32'h0BADF00D);
    step();

    // Reset asserted in the middle of a wait-stated read
    apply_stimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 10'h004);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t6_in_rwait", {31'd0, ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_output("t6_rst_ready", {31'd0, ready}, 32'd1);
    check_output("t6_rst_resp", {31'd0, resp}, 32'd0);
    check_output("t6_rst_rdata", rdata, 32'h0);
    #1 rst_n = 1'b1;
    step();
    apply_stimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 10'h004);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0, SZ_WORD, 10'h000);
    step();
    step();
    step();
    check_output("t6_post_ready", {31'd0, ready}, 32'd1);
    check_output("t6_post_data", rdata, 32'h13572468);
    step();
    use3 = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, SZ_WORD, 10'h008);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 10'h000);
    check_output("t6_post_dut0", rdata, 32'h44332211);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
